// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered UART transmitter.
// Frame = start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Bit period is CLK_FREQ / speed clocks, latched at the start of each frame.
module uart_tx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [19:0]                 speed,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_start,
  output logic                        tx_ready,
  output logic                        tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [31:0] CLK_W     = 32'(CLK_FREQ);
  localparam logic [AW:0] DEPTH_W   = (AW+1)'(FIFO_DEPTH);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic        ODD_BIT   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          ready_q, ovf_q, ne_q;
  logic          push, pop;

  // Serializer state
  state_t        state_q, state_d;
  logic [19:0]   cnt_q, cnt_d, cv_q, cv_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          load, bit_end, avail, spd_ok;
  logic [19:0]   divisor;

  // A write is honoured only against the registered ready flag, so a pop in
  // the same cycle never makes room for a write into a full FIFO.
  assign push    = tx_start & ready_q;
  // ne_q lags count by one cycle; this gives the FIFO one cycle to show the
  // new entry in fifo_count before the serializer takes it.
  assign avail   = ne_q && (count_q != '0);
  assign spd_ok  = (speed != 20'd0) && ({12'd0, speed} <= CLK_W);
  assign divisor = (speed == 20'd0) ? 20'd1 : speed;
  assign bit_end = (cnt_q == cv_q - 20'd1);

  // FIFO occupancy next-state
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // FIFO data array; no reset needed, entries are only read once written
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  // FIFO pointers, count, ready and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      ovf_q    <= 1'b0;
      ne_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      ready_q <= (count_d != DEPTH_W);
      ne_q    <= (count_q != '0);
      if (tx_start && !ready_q) ovf_q <= 1'b1;
    end
  end

  // Serializer next-state, bit timing and line level
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    cv_d    = cv_q;
    load    = 1'b0;
    pop     = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (avail && spd_ok) load = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end else cnt_d = cnt_q + 20'd1;
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            bit_d   = '0;
          end else bit_d = bit_q + 3'd1;
        end else cnt_d = cnt_q + 20'd1;
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          cnt_d   = '0;
          bit_d   = '0;
        end else cnt_d = cnt_q + 20'd1;
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == STOP_LAST) begin
            // chain straight into the next frame when data is waiting
            if (avail && spd_ok) load = 1'b1;
            else                 state_d = S_IDLE;
          end else bit_d = bit_q + 3'd1;
        end else cnt_d = cnt_q + 20'd1;
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      pop     = 1'b1;
      shift_d = mem_q[rd_ptr_q];
      par_d   = ^mem_q[rd_ptr_q];
      cv_d    = 20'(CLK_W / {12'd0, divisor});
      cnt_d   = '0;
      bit_d   = '0;
      state_d = S_START;
    end
    // line level follows the next state so each bit lasts exactly cv clocks
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d ^ ODD_BIT;
      default:  tx_d = 1'b1;
    endcase
  end

  // Serializer state register; reset abandons any frame in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      cv_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      cv_q    <= cv_d;
      tx_q    <= tx_d;
    end
  end

  assign tx         = tx_q;
  assign tx_ready   = ready_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign tx_busy    = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx.
// The 20-bit speed port cannot hold 10 Mbaud, so all instances run with
// CLK_FREQ = 1 MHz: speed 100_000 -> 10 clocks/bit, 50_000 -> 20 clocks/bit.
module tb_uart_tx;
  localparam int CF = 1_000_000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst2, st, st2;
  logic [19:0] speed;
  logic [7:0]  din, din2;
  logic        rdy, txm, busym, ovfm;
  logic [2:0]  cntm;
  logic        rdy_o, tx_o, busy_o, ovf_o;
  logic [2:0]  cnt_o;
  logic        rdy_e, tx_e, busy_e, ovf_e;
  logic [2:0]  cnt_e;

  uart_tx #(.CLK_FREQ(CF)) dut (
    .clk(clk), .reset(rst), .speed(speed), .tx_data(din), .tx_start(st),
    .tx_ready(rdy), .tx(txm), .tx_busy(busym), .fifo_count(cntm), .overflow(ovfm));

  uart_tx #(.CLK_FREQ(CF), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_o (
    .clk(clk), .reset(rst2), .speed(speed), .tx_data(din2), .tx_start(st2),
    .tx_ready(rdy_o), .tx(tx_o), .tx_busy(busy_o), .fifo_count(cnt_o), .overflow(ovf_o));

  uart_tx #(.CLK_FREQ(CF), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_e (
    .clk(clk), .reset(rst2), .speed(speed), .tx_data(din2), .tx_start(st2),
    .tx_ready(rdy_e), .tx(tx_e), .tx_busy(busy_e), .fifo_count(cnt_e), .overflow(ovf_e));

  typedef struct { logic [7:0] d; int cv; } ent_t;
  ent_t sb_q[$];
  int total = 0, bad = 0, nframes = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // expected line level for bit slot idx of a parity/2-stop frame
  function automatic logic abit(input logic [7:0] d, input logic odd, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9) return (^d) ^ odd;
    return 1'b1;
  endfunction

  // write one byte to the main instance; expected frame queued if accepted
  task automatic wr(input logic [7:0] d, input int cv, input bit keep);
    @(negedge clk);
    din = d; st = 1'b1;
    @(posedge clk);
    #1 st = 1'b0;
    if (keep) begin
      ent_t e;
      e.d = d; e.cv = cv;
      sb_q.push_back(e);
    end
  endtask

  task automatic wr2(input logic [7:0] d);
    @(negedge clk);
    din2 = d; st2 = 1'b1;
    @(posedge clk);
    #1 st2 = 1'b0;
  endtask

  // frame monitor on the main instance: per-clock level check and decode
  initial begin : mon
    ent_t        e;
    logic [7:0]  got;
    int          errs, b;
    logic        expb;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && txm === 1'b0) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
          e.d = 8'h00; e.cv = 10;
        end else e = sb_q.pop_front();
        errs = 0; got = 8'h00;
        for (int i = 0; i < 10*e.cv; i++) begin
          if (i > 0) @(negedge clk);
          b = i / e.cv;
          expb = (b == 0) ? 1'b0 : (b <= 8) ? e.d[b-1] : 1'b1;
          if (txm !== expb) errs++;
          if ((i % e.cv) == e.cv/2 && b >= 1 && b <= 8) got[b-1] = txm;
        end
        chk("frame_bits", errs, 0);
        chk("frame_data", {24'd0, got}, {24'd0, e.d});
        nframes++;
      end
    end
  end

  initial begin
    #400_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int eo, ee, er;
    rst = 1'b1; rst2 = 1'b1; st = 1'b0; st2 = 1'b0;
    din = 8'h00; din2 = 8'h00; speed = 20'd100_000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx",   32'(txm),   1);
    chk("rst_busy", 32'(busym), 0);
    chk("rst_rdy",  32'(rdy),   1);
    chk("rst_cnt",  32'(cntm),  0);
    chk("rst_ovf",  32'(ovfm),  0);
    chk("rst_tx_o", 32'(tx_o),  1);
    rst = 1'b0; rst2 = 1'b0;
    repeat (3) @(posedge clk);

    // 1: single byte, latency and busy release
    wr(8'hA5, 10, 1);
    chk("t1_cnt",  32'(cntm),  1);
    chk("t1_busy", 32'(busym), 1);
    @(posedge clk); #1 chk("t1_lat1", 32'(txm), 1);
    @(posedge clk); #1 chk("t1_lat2", 32'(txm), 0);
    repeat (99) @(posedge clk);
    #1 chk("t1_busy_stop", 32'(busym), 1);
    chk("t1_stop", 32'(txm), 1);
    @(posedge clk); #1 chk("t1_busy_end", 32'(busym), 0);

    // 2: back-to-back frames
    repeat (5) @(posedge clk);
    wr(8'h00, 10, 1); chk("t2_cnt1", 32'(cntm), 1);
    wr(8'hFF, 10, 1); chk("t2_cnt2", 32'(cntm), 2);
    @(posedge clk); #1 chk("t2_cnt3", 32'(cntm), 1);
    chk("t2_start", 32'(txm), 0);
    repeat (100) @(posedge clk);
    #1 chk("t2_cnt4", 32'(cntm), 0);
    chk("t2_b2b", 32'(txm), 0);
    repeat (100) @(posedge clk);
    #1 chk("t2_idle", 32'(txm), 1);
    chk("t2_busy", 32'(busym), 0);

    // 3: fill with speed=0, overflow, then release
    speed = 20'd0;
    for (int i = 0; i < 4; i++) wr(8'h10 + 8'(i), 10, 1);
    chk("t3_rdy_full", 32'(rdy),  0);
    chk("t3_cnt_full", 32'(cntm), 4);
    chk("t3_ovf0",     32'(ovfm), 0);
    wr(8'h99, 10, 0);
    chk("t3_ovf", 32'(ovfm), 1);
    chk("t3_cnt", 32'(cntm), 4);
    er = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (txm !== 1'b1) er++;
    end
    chk("t3_tx_hold", er, 0);
    speed = 20'd100_000;
    repeat (420) @(posedge clk);
    #1 chk("t3_sb_empty", sb_q.size(), 0);
    chk("t3_ovf_sticky", 32'(ovfm), 1);
    chk("t3_rdy", 32'(rdy), 1);

    // 4: parity odd/even, two stop bits
    repeat (5) @(posedge clk);
    wr2(8'h03);
    @(posedge clk);
    eo = 0; ee = 0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk); #1;
      if (tx_o !== abit(8'h03, 1'b1, i/10)) eo++;
      if (tx_e !== abit(8'h03, 1'b0, i/10)) ee++;
      if (i == 95) begin
        chk("t4_par_odd",  32'(tx_o), 1);
        chk("t4_par_even", 32'(tx_e), 0);
      end
      if (i == 115) chk("t4_stop2_busy", 32'(busy_o), 1);
    end
    chk("t4_frame_odd",  eo, 0);
    chk("t4_frame_even", ee, 0);
    @(posedge clk); #1 chk("t4_busy_end", 32'(busy_o), 0);

    // 5: reset during D2 with one byte still queued
    repeat (5) @(posedge clk);
    wr2(8'hAA); wr2(8'h55);
    @(posedge clk);
    repeat (34) @(posedge clk);
    #1 chk("t5_d2", 32'(tx_o), 0);
    chk("t5_cnt_pre", 32'(cnt_o), 1);
    rst2 = 1'b1;
    @(posedge clk);
    #1 rst2 = 1'b0;
    chk("t5_tx",   32'(tx_o),   1);
    chk("t5_cnt",  32'(cnt_o),  0);
    chk("t5_busy", 32'(busy_o), 0);
    chk("t5_tx_e", 32'(tx_e),   1);
    er = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (tx_o !== 1'b1 || busy_o !== 1'b0) er++;
    end
    chk("t5_quiet", er, 0);

    // 6: speed change mid-frame applies to the next frame only
    wr(8'h3C, 10, 1);
    wr(8'hC3, 20, 1);
    repeat (50) @(posedge clk);
    speed = 20'd50_000;
    repeat (330) @(posedge clk);
    #1 chk("t6_sb_empty", sb_q.size(), 0);
    chk("t6_idle", 32'(txm), 1);
    chk("frames", nframes, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
